// File: rtl/flight_physics.sv
// Bird motion controller: owns the bird bounding box and vertical velocity.
// Advances once per frame Tick in either manual stepping or gravity/flap physics mode.
module flight_physics #(
    parameter int POS_W      = 10,
    parameter int VEL_W      = 8,
    parameter int X_LEFT     = 230,
    parameter int BIRD_W     = 20,
    parameter int BIRD_H     = 20,
    parameter int Y_INIT     = 220,
    parameter int Y_MIN      = 4,
    parameter int Y_MAX_T    = 620,
    parameter int STEP       = 4,
    parameter int JUMP_V     = 8,
    parameter int GRAVITY    = 1,
    parameter int MAX_FALL_V = 12
) (
    input  logic                    Clk,
    input  logic                    reset_n,
    input  logic                    Tick,
    input  logic                    Mode,
    input  logic                    Start,
    input  logic                    Stop,
    input  logic                    Ack,
    input  logic                    BtnU,
    input  logic                    BtnD,
    output logic [POS_W-1:0]        Bird_X_L,
    output logic [POS_W-1:0]        Bird_X_R,
    output logic [POS_W-1:0]        Bird_Y_T,
    output logic [POS_W-1:0]        Bird_Y_B,
    output logic signed [VEL_W-1:0] VertSpeed,
    output logic                    q_Initial,
    output logic                    q_Flight,
    output logic                    q_Dying,
    output logic                    q_Stop,
    output logic                    HitFloor,
    output logic                    HitCeiling
);

    // Two guard bits keep position + velocity arithmetic free of wrap-around.
    localparam int PW  = POS_W + 2;
    localparam int VW1 = VEL_W + 1;

    localparam logic signed [PW-1:0]    Y_MIN_S    = PW'(Y_MIN);
    localparam logic signed [PW-1:0]    Y_MAX_S    = PW'(Y_MAX_T);
    localparam logic signed [PW-1:0]    STEP_S     = PW'(STEP);
    localparam logic signed [VW1-1:0]   GRAV_S     = VW1'(GRAVITY);
    localparam logic signed [VW1-1:0]   MAXV_S     = VW1'(MAX_FALL_V);
    localparam logic signed [VEL_W-1:0] MAXV_N     = VEL_W'(MAX_FALL_V);
    localparam logic signed [VEL_W-1:0] JUMP_NEG   = VEL_W'(-JUMP_V);
    localparam logic [POS_W-1:0]        Y_INIT_P   = POS_W'(Y_INIT);
    localparam logic [POS_W-1:0]        Y_MIN_P    = POS_W'(Y_MIN);
    localparam logic [POS_W-1:0]        Y_MAX_P    = POS_W'(Y_MAX_T);
    localparam logic [POS_W-1:0]        BIRD_H_OFS = POS_W'(BIRD_H - 1);

    typedef enum logic [3:0] {
        S_INITIAL = 4'b0001,
        S_FLIGHT  = 4'b0010,
        S_DYING   = 4'b0100,
        S_STOP    = 4'b1000
    } state_e;

    state_e                  state_q, state_d;
    logic [POS_W-1:0]        yT_q, yT_d, yB_q;
    logic signed [VEL_W-1:0] vel_q, vel_d;
    logic                    flap_q, flap_d;
    logic                    mode_q, mode_d;
    logic                    btnUPrev_q;
    logic                    hitFloor_q, hitFloor_d;
    logic                    hitCeil_q, hitCeil_d;

    logic signed [PW-1:0]    yExt, velExt, yNext;
    logic signed [VW1-1:0]   velInc;
    logic signed [VEL_W-1:0] velGrav, velNext;
    logic                    btnURise, doTick, physics, useFlap;

    assign yExt     = $signed({2'b00, yT_q});
    assign velExt   = $signed({{(PW-VEL_W){vel_q[VEL_W-1]}}, vel_q});
    assign velInc   = $signed({vel_q[VEL_W-1], vel_q}) + GRAV_S;
    assign velGrav  = (velInc > MAXV_S) ? MAXV_N : velInc[VEL_W-1:0];
    assign btnURise = BtnU & ~btnUPrev_q;

    always_comb begin
        state_d    = state_q;
        yT_d       = yT_q;
        vel_d      = vel_q;
        flap_d     = flap_q;
        mode_d     = mode_q;
        hitFloor_d = 1'b0;
        hitCeil_d  = 1'b0;
        doTick     = 1'b0;
        physics    = 1'b0;
        useFlap    = 1'b0;
        yNext      = yExt;
        velNext    = vel_q;

        unique case (state_q)
            S_INITIAL: begin
                yT_d   = Y_INIT_P;
                vel_d  = '0;
                flap_d = 1'b0;
                mode_d = Mode;
                if (Start) state_d = S_FLIGHT;
            end
            S_FLIGHT: begin
                if (Stop) begin
                    state_d = mode_q ? S_DYING : S_STOP;
                    flap_d  = 1'b0;
                end else begin
                    flap_d = flap_q | btnURise;
                    if (Tick) begin
                        doTick  = 1'b1;
                        physics = mode_q;
                        useFlap = mode_q & flap_q;
                        // An edge arriving with this tick survives for the next one.
                        if (mode_q) flap_d = btnURise;
                    end
                end
            end
            S_DYING: begin
                flap_d = 1'b0;
                if (Tick) begin
                    doTick  = 1'b1;
                    physics = 1'b1;
                end
            end
            S_STOP: begin
                flap_d = 1'b0;
                if (Ack) begin
                    state_d = S_INITIAL;
                    yT_d    = Y_INIT_P;
                    vel_d   = '0;
                end
            end
            default: begin
                state_d = S_INITIAL;
                yT_d    = Y_INIT_P;
                vel_d   = '0;
                flap_d  = 1'b0;
            end
        endcase

        if (doTick) begin
            if (physics) begin
                yNext   = yExt + velExt;
                velNext = useFlap ? JUMP_NEG : velGrav;
            end else begin
                velNext = '0;
                if (BtnU)      yNext = yExt - STEP_S;
                else if (BtnD) yNext = yExt + STEP_S;
            end

            // Exact landing on a bound raises the flag; only overshoot kills velocity.
            if (yNext <= Y_MIN_S) begin
                yT_d      = Y_MIN_P;
                hitCeil_d = 1'b1;
                if (physics && (yNext < Y_MIN_S)) velNext = useFlap ? JUMP_NEG : '0;
            end else if (yNext >= Y_MAX_S) begin
                yT_d       = Y_MAX_P;
                hitFloor_d = 1'b1;
                if (physics && (yNext > Y_MAX_S)) velNext = '0;
                if (state_q == S_DYING) state_d = S_STOP;
            end else begin
                yT_d = yNext[POS_W-1:0];
            end
            vel_d = velNext;
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_INITIAL;
            yT_q       <= Y_INIT_P;
            yB_q       <= Y_INIT_P + BIRD_H_OFS;
            vel_q      <= '0;
            flap_q     <= 1'b0;
            mode_q     <= 1'b0;
            btnUPrev_q <= 1'b0;
            hitFloor_q <= 1'b0;
            hitCeil_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            yT_q       <= yT_d;
            yB_q       <= yT_d + BIRD_H_OFS;
            vel_q      <= vel_d;
            flap_q     <= flap_d;
            mode_q     <= mode_d;
            btnUPrev_q <= BtnU;
            hitFloor_q <= hitFloor_d;
            hitCeil_q  <= hitCeil_d;
        end
    end

    assign Bird_X_L   = POS_W'(X_LEFT);
    assign Bird_X_R   = POS_W'(X_LEFT + BIRD_W - 1);
    assign Bird_Y_T   = yT_q;
    assign Bird_Y_B   = yB_q;
    assign VertSpeed  = vel_q;
    assign q_Initial  = state_q[0];
    assign q_Flight   = state_q[1];
    assign q_Dying    = state_q[2];
    assign q_Stop     = state_q[3];
    assign HitFloor   = hitFloor_q;
    assign HitCeiling = hitCeil_q;

endmodule
